// File: rtl/imem_loader_if.sv
// Valid/ready word stream from the boot/debug channel into the loader.
interface imem_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams an image in, NOP-pads, releases the core.
// Optional LOADER_CHECKSUM_EN: trailing checksum word verified before release.
module imem_loader #(
    parameter int          DEPTH     = 32,
    parameter int          AW        = 5,
    parameter logic [31:0] FILL_WORD = 32'hC000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    imem_loader_if.slave  s,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          core_hold_o,
    output logic          done_o,
    output logic          error_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        FILL,
        DONE,
        ERR
    } state_t;

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic          mem_we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          hold_q;
    logic          done_q;
    logic          err_q;
    logic [AW:0]   cnt_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   acc_q;
`endif

    logic xfer;
    logic restart;

`ifdef LOADER_CHECKSUM_EN
    assign s.s_ready = (state_q == LOAD) || (state_q == CSUM);
`else
    assign s.s_ready = (state_q == LOAD);
`endif

    assign xfer    = s.s_valid && s.s_ready;
    // start only counts when no load is in flight
    assign restart = start_i &&
                     ((state_q == IDLE) || (state_q == DONE) ||
                      (state_q == ERR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (restart) begin
                state_q <= LOAD;
                ptr_q   <= '0;
                cnt_q   <= '0;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
                hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                acc_q   <= '0;
`endif
            end else begin
                unique case (state_q)
                    IDLE: hold_q <= 1'b1;
                    LOAD: begin
                        if (xfer) begin
                            mem_we_q <= 1'b1;
                            addr_q   <= ptr_q;
                            wdata_q  <= s.s_data;
                            ptr_q    <= ptr_q + 1'b1;
                            cnt_q    <= cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            acc_q    <= acc_q + s.s_data;
                            if (s.s_last)
                                state_q <= CSUM;
`else
                            if (s.s_last)
                                state_q <= (ptr_q == LAST) ? DONE : FILL;
`endif
                            else if (ptr_q == LAST)
                                state_q <= ERR;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (xfer) begin
                            if (s.s_data != acc_q)
                                state_q <= ERR;
                            else if (cnt_q == FULL)
                                state_q <= DONE;
                            else
                                state_q <= FILL;
                        end
                    end
`endif
                    FILL: begin
                        mem_we_q <= 1'b1;
                        addr_q   <= ptr_q;
                        wdata_q  <= FILL_WORD;
                        ptr_q    <= ptr_q + 1'b1;
                        if (ptr_q == LAST)
                            state_q <= DONE;
                    end
                    DONE: begin
                        done_q <= 1'b1;
                        hold_q <= 1'b0;
                    end
                    ERR: begin
                        err_q  <= 1'b1;
                        hold_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign core_hold_o = hold_q;
    assign done_o      = done_q;
    assign error_o     = err_q;
    assign count_o     = cnt_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: takes a valid/ready word stream from a host or boot channel and writes the 32-entry instruction memory that the fetch stage reads.
- Holds the core pipeline in reset (core_hold) until a complete image is in memory.
- Pads unused entries with a NOP word so fetch never runs into stale contents.
- Sits between the boot/debug channel and the instruction memory write port.

Parameters:
- DEPTH, 32, number of instruction-memory words; power of two.
- AW, 5, address width, log2(DEPTH).
- FILL_WORD, 32'hC000_0000, pad word. Opcode field [31:30]=2'b11 decodes to a NOP: execute result is 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new load.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  stream word (instruction, or checksum when the option is on).
- s_last  in  1  marks the final instruction word of the image.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  AW  word address (fetch index = pc>>2).
- mem_wdata  out  32  write data.
- core_hold  out  1  high = keep fetch/execute/writeback in reset.
- done  out  1  image loaded and padded; core released.
- error  out  1  load failed: overflow or checksum mismatch.
- count  out  AW+1  number of instruction words accepted, 0..DEPTH.

Behaviour:
- Reset values: state IDLE, ptr=0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, error=0, count=0. Reset mid-load aborts immediately; partially written memory is not cleaned.
- States: IDLE, LOAD, CSUM (option only), FILL, DONE, ERR.
- s_ready is high only in LOAD and CSUM. It is decoded from registered state, with no combinational path from s_valid.
- A word transfers when s_valid && s_ready are both high.
- All memory-port outputs are registered. A word accepted in cycle N appears on mem_we/mem_addr/mem_wdata in cycle N+1, with mem_we high for exactly 1 cycle.
- IDLE: core_hold=1. On start: go to LOAD, ptr=0, count=0, error=0, done=0.
- LOAD, on each transfer: write s_data at ptr, ptr++, count++.
  - s_last=1 and ptr<DEPTH-1: go to FILL (or CSUM when the option is on).
  - s_last=1 and ptr==DEPTH-1: go to DONE (or CSUM); no padding.
  - s_last=0 and ptr==DEPTH-1: the word is still written, then go to ERR (overflow). Stream words after that are not accepted.
- FILL:
  - Write FILL_WORD at ptr, one write per cycle, ptr++.
  - After the write at DEPTH-1, go to DONE.
  - s_ready=0 throughout.
- DONE:
  - done=1 and core_hold=0, both registered; they change on the cycle after the final memory write is issued.
  - On start: go to LOAD, done=0, core_hold=1 in the next cycle.
- ERR: error=1, core_hold=1. Exit only via start (to LOAD, error cleared) or rst.
- start while in LOAD, CSUM or FILL is ignored.
- ptr wraps modulo DEPTH, but it is never used after a wrap because every path out of address DEPTH-1 leaves LOAD/FILL.
- count saturates naturally at DEPTH. It holds its value through DONE and ERR until the next start.
- s_data bits are not interpreted, except for the checksum when the option is on.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator is cleared on start.
  - Each accepted instruction word is added to it, wrapping mod 2^32.
  - After the s_last transfer, the FSM enters CSUM with s_ready=1. The next transfer is the checksum and is not written to memory.
  - Checksum equals the accumulator: go to FILL, or to DONE if memory is full.
  - Mismatch: go to ERR.
  - s_last during the CSUM transfer is don't-care.
- Undefined: there is no CSUM state and no accumulator; s_last goes directly to FILL or DONE.

Test Plan:
- Reset, then start; stream 3 words 0x0220_0000, 0x4220_0000, 0x0000_0000 (last) -> writes at addr 0..2 with 1-cycle latency; FILL writes 0xC000_0000 at 3..31; done=1, core_hold=0, count=3.
- Full image: 32 words with s_last on word 31 -> no FILL writes; done asserts 1 cycle after the addr-31 write; count=32.
- Overflow: 32 words with s_last never set -> addr 31 written; error=1, core_hold=1, s_ready=0. A subsequent start clears error and reloads.
- Backpressure and gaps: toggle s_valid randomly; pulse start mid-LOAD -> writes are contiguous with no duplicates; start is ignored; final memory matches the stream.
- Async rst asserted mid-FILL -> all outputs at reset values immediately; core_hold=1; a fresh start reloads correctly.
- LOADER_CHECKSUM_EN: words 1, 2, 3 (last), then checksum 6 -> done. Repeat with checksum 7 -> error=1, and the 7 is not written to memory.
